// File: rtl/word16_serializer.sv
// Purpose: parallel-to-serial shifter holding one active word and one pending word.
// Latency: a word accepted at edge N presents its first bit after edge N+1; consecutive words stream with no gap.
// Backpressure: a bit is held stable until sout_ready takes it; load_ready drops while the pending slot is full.
module word16_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_in,
  output logic             o_load_ready,
  output logic             o_sout,
  output logic             o_sout_valid,
  input  logic             i_sout_ready,
  output logic             o_sout_last,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam bit SINGLE_BIT = (WIDTH == 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_pnd;
  logic             r_pnd_full;
  logic [CW-1:0]    r_cnt;
  logic             r_sout_valid;
  logic             r_sout_last;

  logic             w_load_acc;
  logic             w_bit_acc;
  logic             w_word_done;
  logic [WIDTH-1:0] w_sr_shifted;
  logic [CW-1:0]    w_cnt_inc;

  // Handshake qualifiers; load_ready depends only on the registered pending flag.
  assign w_load_acc   = i_load & ~r_pnd_full;
  assign w_bit_acc    = r_sout_valid & i_sout_ready;
  assign w_word_done  = (r_cnt == LAST_CNT);
  assign w_cnt_inc    = r_cnt + CW'(1);
  assign w_sr_shifted = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);

  // Control FSM plus datapath: pending slot fill, word hand-off and bit shifting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_sr         <= '0;
      r_pnd        <= '0;
      r_pnd_full   <= 1'b0;
      r_cnt        <= '0;
      r_sout_valid <= 1'b0;
      r_sout_last  <= 1'b0;
    end else begin
      // A new word lands in the pending slot whenever it is free.
      if (w_load_acc) begin
        r_pnd      <= i_in;
        r_pnd_full <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_pnd_full) begin
            // Promote the pending word; a load taken on this edge keeps the slot full.
            r_sr         <= r_pnd;
            r_cnt        <= '0;
            r_pnd_full   <= w_load_acc;
            r_state      <= ST_SHIFT;
            r_sout_valid <= 1'b1;
            r_sout_last  <= SINGLE_BIT;
          end
        end
        ST_SHIFT: begin
          if (w_bit_acc) begin
            if (w_word_done) begin
              r_cnt <= '0;
              if (r_pnd_full) begin
                // Seamless hand-off: next word's first bit follows immediately.
                r_sr        <= r_pnd;
                r_pnd_full  <= w_load_acc;
                r_sout_last <= SINGLE_BIT;
              end else begin
                r_sr         <= w_sr_shifted;
                r_state      <= ST_IDLE;
                r_sout_valid <= 1'b0;
                r_sout_last  <= 1'b0;
              end
            end else begin
              r_sr        <= w_sr_shifted;
              r_cnt       <= w_cnt_inc;
              r_sout_last <= (w_cnt_inc == LAST_CNT);
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_sout_valid <= 1'b0;
          r_sout_last  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are taken straight from state; the shift register is zero when idle.
  assign o_load_ready = ~r_pnd_full;
  assign o_sout       = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
  assign o_sout_valid = r_sout_valid;
  assign o_sout_last  = r_sout_last;
  assign o_busy       = (r_state == ST_SHIFT) | r_pnd_full;

endmodule

// File: tb/tb_word16_serializer.sv
// Bench for word16_serializer: MSB-first and LSB-first instances share one stimulus stream.
// A queue-based reference model predicts every serial bit from the accepted words.
module tb_word16_serializer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         sout_ready = 1'b0;

  logic m_load_ready, m_sout, m_sout_valid, m_sout_last, m_busy;
  logic l_load_ready, l_sout, l_sout_valid, l_sout_last, l_busy;

  int total = 0;
  int bad   = 0;

  // Expected {last, bit} sequences for each instance.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  bit   m_stall = 0, l_stall = 0;
  logic m_prev_sout, m_prev_last, l_prev_sout, l_prev_last;

  word16_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_in(din),
    .o_load_ready(m_load_ready), .o_sout(m_sout), .o_sout_valid(m_sout_valid),
    .i_sout_ready(sout_ready), .o_sout_last(m_sout_last), .o_busy(m_busy)
  );

  word16_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_in(din),
    .o_load_ready(l_load_ready), .o_sout(l_sout), .o_sout_valid(l_sout_valid),
    .i_sout_ready(sout_ready), .o_sout_last(l_sout_last), .o_busy(l_busy)
  );

  always #5 clk = ~clk;

  // Reference model: on each accepted beat compare against the predicted stream;
  // on each accepted load append that word's bits in transmit order.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_n) begin
      q_m.delete();
      q_l.delete();
      m_stall = 0;
      l_stall = 0;
    end else begin
      if (m_stall) begin
        total++;
        if (m_sout_valid !== 1'b1 || m_sout !== m_prev_sout || m_sout_last !== m_prev_last) begin
          bad++;
          $display("FAIL msb_stall_hold: got v=%b d=%b l=%b want v=1 d=%b l=%b", m_sout_valid, m_sout, m_sout_last, m_prev_sout, m_prev_last);
        end
      end
      if (l_stall) begin
        total++;
        if (l_sout_valid !== 1'b1 || l_sout !== l_prev_sout || l_sout_last !== l_prev_last) begin
          bad++;
          $display("FAIL lsb_stall_hold: got v=%b d=%b l=%b want v=1 d=%b l=%b", l_sout_valid, l_sout, l_sout_last, l_prev_sout, l_prev_last);
        end
      end
      if (m_sout_valid && sout_ready) begin
        total++;
        if (q_m.size() == 0) begin
          bad++;
          $display("FAIL msb_unexpected_bit: got a valid bit, want none");
        end else begin
          e = q_m.pop_front();
          if ({m_sout_last, m_sout} !== e) begin
            bad++;
            $display("FAIL msb_bit: got last,bit=%b%b want %b", m_sout_last, m_sout, e);
          end
        end
      end
      if (l_sout_valid && sout_ready) begin
        total++;
        if (q_l.size() == 0) begin
          bad++;
          $display("FAIL lsb_unexpected_bit: got a valid bit, want none");
        end else begin
          e = q_l.pop_front();
          if ({l_sout_last, l_sout} !== e) begin
            bad++;
            $display("FAIL lsb_bit: got last,bit=%b%b want %b", l_sout_last, l_sout, e);
          end
        end
      end
      m_stall     = m_sout_valid && !sout_ready;
      l_stall     = l_sout_valid && !sout_ready;
      m_prev_sout = m_sout;
      m_prev_last = m_sout_last;
      l_prev_sout = l_sout;
      l_prev_last = l_sout_last;
      if (load && m_load_ready) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back({(i == W - 1), din[W-1-i]});
          q_l.push_back({(i == W - 1), din[i]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [W-1:0] w);
    int n = 0;
    load = 1'b1;
    din  = w;
    while (!m_load_ready && n < 200) begin
      step();
      n++;
    end
    total++;
    if (!m_load_ready) begin
      bad++;
      $display("FAIL load_timeout: got load_ready=0 after %0d cycles, want 1", n);
    end
    step();
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || l_busy) && n < 500) begin
      step();
      n++;
    end
    total++;
    if (m_busy !== 1'b0 || l_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout: got busy=%b/%b, want 0/0", m_busy, l_busy);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    step();
    step();
    total++;
    if (m_sout_valid !== 1'b0 || m_sout !== 1'b0 || m_sout_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_msb_out: got v=%b d=%b l=%b want 000", m_sout_valid, m_sout, m_sout_last);
    end
    total++;
    if (m_busy !== 1'b0 || m_load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_msb_flags: got busy=%b rdy=%b want 0 1", m_busy, m_load_ready);
    end
    total++;
    if (l_sout_valid !== 1'b0 || l_busy !== 1'b0 || l_load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_lsb: got v=%b busy=%b rdy=%b want 0 0 1", l_sout_valid, l_busy, l_load_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [W-1:0] got_m = '0;
    logic [W-1:0] got_l = '0;
    sout_ready = 1'b1;
    load = 1'b1;
    din  = 16'd123;
    total++;
    if (m_load_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready: got load_ready=%b want 1", m_load_ready);
    end
    step();
    load = 1'b0;
    for (int i = 1; i <= W; i++) begin
      step();
      total++;
      if (m_sout_valid !== 1'b1 || m_sout_last !== (i == W)) begin
        bad++;
        $display("FAIL single_beat%0d: got v=%b l=%b want v=1 l=%b", i, m_sout_valid, m_sout_last, (i == W));
      end
      got_m = {got_m[W-2:0], m_sout};
      got_l = {l_sout, got_l[W-1:1]};
    end
    total++;
    if (got_m !== 16'h007B) begin
      bad++;
      $display("FAIL single_word_msb: got %h want 007b", got_m);
    end
    total++;
    if (got_l !== 16'h007B) begin
      bad++;
      $display("FAIL single_word_lsb: got %h want 007b", got_l);
    end
    step();
    total++;
    if (m_sout_valid !== 1'b0 || m_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle_17: got v=%b busy=%b want 0 0", m_sout_valid, m_busy);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int lastv = -1;
    int nvalid = 0;
    int lasts[$];
    sout_ready = 1'b1;
    load = 1'b1;
    din  = 16'hA5A5;
    step();
    din  = 16'h0F0F;
    for (int c = 0; c < 40; c++) begin
      bit acc;
      acc = load && m_load_ready;
      if (m_sout_valid) begin
        nvalid++;
        if (first < 0) first = c;
        lastv = c;
        if (m_sout_last) lasts.push_back(c - first + 1);
      end
      step();
      if (acc) load = 1'b0;
    end
    total++;
    if (nvalid != 32 || (lastv - first + 1) != 32) begin
      bad++;
      $display("FAIL b2b_contiguous: got %0d valid over span %0d, want 32 over 32", nvalid, lastv - first + 1);
    end
    total++;
    if (lasts.size() != 2 || lasts[0] != 16 || lasts[1] != 32) begin
      bad++;
      $display("FAIL b2b_last_pos: got %0d lasts (first at %0d), want at 16 and 32", lasts.size(), (lasts.size() > 0) ? lasts[0] : -1);
    end
    load = 1'b0;
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got = '0;
    int   nb = 0;
    int   c = 0;
    logic ps = 1'b0;
    logic pl = 1'b0;
    bit   stalled = 0;
    sout_ready = 1'b0;
    load_word(16'h8001);
    while (nb < W && c < 400) begin
      if (stalled) begin
        total++;
        if (m_sout_valid !== 1'b1 || m_sout !== ps || m_sout_last !== pl) begin
          bad++;
          $display("FAIL bp_stable: got v=%b d=%b l=%b want v=1 d=%b l=%b", m_sout_valid, m_sout, m_sout_last, ps, pl);
        end
      end
      sout_ready = 1'($urandom_range(0, 1));
      if (m_sout_valid && sout_ready) begin
        nb++;
        got = {got[W-2:0], m_sout};
        total++;
        if (m_sout_last !== (nb == W)) begin
          bad++;
          $display("FAIL bp_last%0d: got %b want %b", nb, m_sout_last, (nb == W));
        end
      end
      stalled = m_sout_valid && !sout_ready;
      ps = m_sout;
      pl = m_sout_last;
      step();
      c++;
    end
    total++;
    if (nb != W || got !== 16'h8001) begin
      bad++;
      $display("FAIL bp_word: got %0d bits value %h, want 16 bits value 8001", nb, got);
    end
    sout_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_full();
    int n = 0;
    sout_ready = 1'b0;
    load_word(16'h1111);
    load_word(16'h2222);
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 16'($urandom);
      step();
      total++;
      if (m_load_ready !== 1'b0 || m_busy !== 1'b1) begin
        bad++;
        $display("FAIL full_refuse%0d: got rdy=%b busy=%b want 0 1", i, m_load_ready, m_busy);
      end
    end
    din = 16'h3333;
    sout_ready = 1'b1;
    while (!m_load_ready && n < 100) begin
      step();
      n++;
    end
    total++;
    if (n != W) begin
      bad++;
      $display("FAIL full_third_delay: got %0d beats before slot free, want 16", n);
    end
    step();
    load = 1'b0;
    wait_idle();
  endtask

  task automatic test_lsb_first();
    sout_ready = 1'b1;
    load = 1'b1;
    din  = 16'h0001;
    step();
    load = 1'b0;
    step();
    total++;
    if (l_sout_valid !== 1'b1 || l_sout !== 1'b1 || m_sout !== 1'b0) begin
      bad++;
      $display("FAIL lsb_first_bit: got v=%b lsb=%b msb=%b want 1 1 0", l_sout_valid, l_sout, m_sout);
    end
    for (int i = 2; i <= W; i++) begin
      step();
      total++;
      if (l_sout_valid !== 1'b1 || l_sout !== 1'b0) begin
        bad++;
        $display("FAIL lsb_bit%0d: got v=%b d=%b want 1 0", i, l_sout_valid, l_sout);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    int ones = 0;
    sout_ready = 1'b1;
    load_word(16'hFFFF);
    load_word(16'h1234);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    total++;
    if (m_sout_valid !== 1'b0 || m_busy !== 1'b0 || m_load_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_msb: got v=%b busy=%b rdy=%b want 0 0 1", m_sout_valid, m_busy, m_load_ready);
    end
    total++;
    if (l_sout_valid !== 1'b0 || l_busy !== 1'b0 || l_load_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_lsb: got v=%b busy=%b rdy=%b want 0 0 1", l_sout_valid, l_busy, l_load_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    load_word(16'hFFFF);
    for (int c = 0; c < 30; c++) begin
      if (m_sout_valid) begin
        nvalid++;
        if (m_sout === 1'b1) ones++;
      end
      step();
    end
    total++;
    if (nvalid != W || ones != W) begin
      bad++;
      $display("FAIL midreset_restream: got %0d valid %0d ones, want 16 16", nvalid, ones);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full();
    test_lsb_first();
    test_reset_mid();
    repeat (2) step();
    total++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      bad++;
      $display("FAIL model_drained: got %0d/%0d bits outstanding, want 0/0", q_m.size(), q_l.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
